line_offset_encoder: RTL

- Sequential 32-to-5 offset encoder for the cache: the inverse direction of the offset-to-word-select decoder.
- Accepts a 32-bit per-word mask for one cache line, such as dirty or valid words. Emits the 5-bit offset of every set bit in ascending order, one per handshake.
- Feeds the writeback/refill datapath, which indexes line words by offset.

---
 rtl/cache_pkg.sv | 16 +
 rtl/line_offset_encoder_if.sv | 28 ++
 rtl/lowest_set_encoder.sv | 25 ++
 rtl/line_offset_encoder.sv | 89 ++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache line definitions used by the line offset encoder.
package cache_pkg;

  localparam int unsigned LINE_WORDS = 32;
  localparam int unsigned OFFSET_W   = 5;

  typedef logic [LINE_WORDS-1:0] line_mask_t;
  typedef logic [OFFSET_W-1:0]   line_offset_t;
  typedef logic [OFFSET_W:0]     line_count_t;

  typedef enum logic {
    IDLE,
    EMIT
  } line_enc_state_t;

endpackage : cache_pkg

// File: rtl/line_offset_encoder_if.sv
// Mask-load and offset-stream handshake bundle for the line offset encoder.
interface line_offset_encoder_if;
  import cache_pkg::*;

  logic         load_valid;
  logic         load_ready;
  line_mask_t   load_mask;
  logic         offset_valid;
  logic         offset_ready;
  line_offset_t offset;
  logic         offset_last;
  line_count_t  remaining;
  logic         abort;
  logic         done;

  // Producer of masks and consumer of offsets.
  modport master (
    output load_valid, load_mask, offset_ready, abort,
    input  load_ready, offset_valid, offset, offset_last, remaining, done
  );

  // The encoder itself.
  modport slave (
    input  load_valid, load_mask, offset_ready, abort,
    output load_ready, offset_valid, offset, offset_last, remaining, done
  );

endinterface : line_offset_encoder_if

// File: rtl/lowest_set_encoder.sv
// Combinational lowest-set-bit priority encoder over one line mask.
module lowest_set_encoder
  import cache_pkg::*;
(
  input  line_mask_t   mask_i,
  output line_offset_t index_o,
  output logic         any_o,
  output logic         single_o
);

  // Scan from the top so the lowest set bit is the last assignment to stick.
  always_comb begin
    index_o = '0;
    for (int unsigned i = LINE_WORDS; i > 0; i--) begin
      if (mask_i[i-1]) index_o = line_offset_t'(i - 1);
    end
  end

  // Exactly one bit set <=> nonzero and clearing the lowest bit leaves zero.
  always_comb begin
    any_o    = (mask_i != '0);
    single_o = any_o && ((mask_i & (mask_i - line_mask_t'(1))) == '0);
  end

endmodule : lowest_set_encoder

// File: rtl/line_offset_encoder.sv
// Sequential 32-to-5 offset encoder: streams the offset of every set mask bit,
// lowest first, one per handshake.
module line_offset_encoder
  import cache_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  line_offset_encoder_if.slave bus
);

  line_enc_state_t state_q, state_d;
  line_mask_t      mask_q, mask_d;
  logic            done_q, done_d;

  line_offset_t    low_idx;
  logic            low_any;
  logic            low_single;
  line_count_t     pop;

  lowest_set_encoder u_lse (
    .mask_i   (mask_q),
    .index_o  (low_idx),
    .any_o    (low_any),
    .single_o (low_single)
  );

  // Popcount of the bits still waiting to be transferred.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      pop = pop + line_count_t'(mask_q[i]);
    end
  end

  // Outputs are derived from registered state only (plus abort gating load).
  always_comb begin
    bus.load_ready   = (state_q == IDLE) && !bus.abort;
    bus.offset_valid = (state_q == EMIT);
    bus.offset       = (state_q == EMIT) ? low_idx    : '0;
    bus.offset_last  = (state_q == EMIT) ? low_single : 1'b0;
    bus.remaining    = (state_q == EMIT) ? pop        : '0;
    bus.done         = done_q;
  end

  // Next-state: load in IDLE, retire lowest bit per transfer in EMIT.
  // Abort has priority over a coincident transfer and suppresses done.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_valid && !bus.abort) begin
          mask_d = bus.load_mask;
          if (bus.load_mask != '0) state_d = EMIT;
          else                     done_d  = 1'b1;
        end
      end
      EMIT: begin
        if (bus.abort) begin
          mask_d  = '0;
          state_d = IDLE;
        end else if (bus.offset_ready) begin
          mask_d = mask_q & (mask_q - line_mask_t'(1));
          if (low_single) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!low_any && state_q == EMIT && !bus.abort) state_d = IDLE;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

endmodule : line_offset_encoder
